// File: rtl/a5_keystream_core.sv
// rtl/a5_keystream_core.sv - A5/1 keystream generator: key/frame load, majority warm-up, throttled bit output
module a5_keystream_core #(
    parameter int MIX_CYCLES = 100,
    parameter int BURST_BITS = 228
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    input  logic        lfsr_clk_en,
    output logic        d,
    output logic        d_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_FRAME,
        S_MIX,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [18:0] r1, r1_n;
    logic [21:0] r2, r2_n;
    logic [22:0] r3, r3_n;
    logic [7:0]  cnt, cnt_n;
    logic [63:0] key_q, key_n;
    logic [21:0] frame_q, frame_n;
    logic        d_n, d_valid_n, done_n;

    logic        fb1, fb2, fb3, maj;
    logic [18:0] r1_maj;
    logic [21:0] r2_maj;
    logic [22:0] r3_maj;
    logic        out_maj;

    assign fb1 = r1[13] ^ r1[16] ^ r1[17] ^ r1[18];
    assign fb2 = r2[20] ^ r2[21];
    assign fb3 = r3[7] ^ r3[20] ^ r3[21] ^ r3[22];
    assign maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);

    // Majority-clocked successor state, shared by MIX and RUN.
    assign r1_maj  = (r1[8]  == maj) ? {r1[17:0], fb1} : r1;
    assign r2_maj  = (r2[10] == maj) ? {r2[20:0], fb2} : r2;
    assign r3_maj  = (r3[10] == maj) ? {r3[21:0], fb3} : r3;
    assign out_maj = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];

    assign busy = (state == S_KEY) || (state == S_FRAME) || (state == S_MIX) || (state == S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
            cnt     <= '0;
            key_q   <= '0;
            frame_q <= '0;
            d       <= 1'b0;
            d_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            r1      <= r1_n;
            r2      <= r2_n;
            r3      <= r3_n;
            cnt     <= cnt_n;
            key_q   <= key_n;
            frame_q <= frame_n;
            d       <= d_n;
            d_valid <= d_valid_n;
            done    <= done_n;
        end
    end

    always_comb begin
        logic inj;
        state_n   = state;
        r1_n      = r1;
        r2_n      = r2;
        r3_n      = r3;
        cnt_n     = cnt;
        key_n     = key_q;
        frame_n   = frame_q;
        d_n       = d;
        d_valid_n = 1'b0;
        done_n    = 1'b0;
        inj       = 1'b0;

        case (state)
            S_KEY, S_FRAME: begin
                inj   = (state == S_KEY) ? key_q[cnt[5:0]] : frame_q[cnt[4:0]];
                r1_n  = {r1[17:0], fb1 ^ inj};
                r2_n  = {r2[20:0], fb2 ^ inj};
                r3_n  = {r3[21:0], fb3 ^ inj};
                cnt_n = cnt + 8'd1;
                if (state == S_KEY && cnt == 8'd63) begin
                    state_n = S_FRAME;
                    cnt_n   = '0;
                end else if (state == S_FRAME && cnt == 8'd21) begin
                    state_n = S_MIX;
                    cnt_n   = '0;
                end
            end
            S_MIX: begin
                r1_n  = r1_maj;
                r2_n  = r2_maj;
                r3_n  = r3_maj;
                cnt_n = cnt + 8'd1;
                if (cnt == 8'(MIX_CYCLES - 1)) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end
            end
            S_RUN: begin
                if (lfsr_clk_en) begin
                    r1_n      = r1_maj;
                    r2_n      = r2_maj;
                    r3_n      = r3_maj;
                    d_n       = out_maj;
                    d_valid_n = 1'b1;
                    cnt_n     = cnt + 8'd1;
                    if (cnt == 8'(BURST_BITS - 1)) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // A start pulse overrides any in-flight step; done from S_DONE is kept.
        if (start) begin
            state_n   = S_KEY;
            key_n     = key;
            frame_n   = frame;
            r1_n      = '0;
            r2_n      = '0;
            r3_n      = '0;
            cnt_n     = '0;
            d_n       = d;
            d_valid_n = 1'b0;
        end
    end

endmodule
